// File: rtl/rx_iq_pkg.sv
// Shared defaults and the IQ quadruple layout for the RX IQ elastic buffer.
package rx_iq_pkg;
  localparam int IQ_W_DEF  = 24;
  localparam int DEPTH_DEF = 16;

  typedef struct packed {
    logic signed [IQ_W_DEF-1:0] rx1_i;
    logic signed [IQ_W_DEF-1:0] rx1_q;
    logic signed [IQ_W_DEF-1:0] rx2_i;
    logic signed [IQ_W_DEF-1:0] rx2_q;
  } iq_quad_t;
endpackage

// File: rtl/rx_iq_buf_ram.sv
// Simple dual-port sample store: one synchronous write port, one read port addressed by the head pointer.
module rx_iq_buf_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Head is read before any same-edge write lands, so a full-FIFO pop+write sees the old entry.
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/rx_iq_buffer.sv
// Elastic RX1/RX2 IQ sample FIFO between the decimators and the bus interface.
// Optional high-water-mark output enabled by defining RX_IQ_BUFFER_HWM_EN.
module rx_iq_buffer
  import rx_iq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IQ_W   = IQ_W_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk_in,
  input  logic                   reset_rx_n,
  input  logic                   flush,
  input  logic                   rx_valid,
  input  logic signed [IQ_W-1:0] rx1_i_in,
  input  logic signed [IQ_W-1:0] rx1_q_in,
  input  logic signed [IQ_W-1:0] rx2_i_in,
  input  logic signed [IQ_W-1:0] rx2_q_in,
  input  logic                   rd_req,
  input  logic                   overrun_clr,
  output logic signed [IQ_W-1:0] RX1_I,
  output logic signed [IQ_W-1:0] RX1_Q,
  output logic signed [IQ_W-1:0] RX2_I,
  output logic signed [IQ_W-1:0] RX2_Q,
  output logic                   in_empty,
  output logic                   full,
  output logic [ADDR_W:0]        level,
  output logic                   iq_overrun
`ifdef RX_IQ_BUFFER_HWM_EN
  ,
  output logic [ADDR_W:0]        hwm
`endif
);
  localparam int EW = 4 * IQ_W;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              ovr_q, ovr_d, rd_req_q, rd_req_d;
  logic [EW-1:0]     out_q, out_d, ram_rdata, wr_entry;
  logic              pop, pop_ok, wr_ok, drop, ram_we;

  assign wr_entry = {rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in};

  always_comb begin
    pop    = rd_req & ~rd_req_q;
    pop_ok = pop & ~empty_q;
    // A pop on a full FIFO frees the slot the incoming sample needs.
    wr_ok  = rx_valid & (~full_q | pop_ok);
    drop   = rx_valid & full_q & ~pop_ok;
    ram_we = wr_ok & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    empty_d  = empty_q;
    full_d   = full_q;
    ovr_d    = ovr_q;
    out_d    = out_q;
    rd_req_d = rd_req;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        out_d    = ram_rdata;
      end
      level_d = level_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop_ok);
      empty_d = (level_d == '0);
      full_d  = (level_d == (ADDR_W+1)'(DEPTH));
      if (drop)             ovr_d = 1'b1;
      else if (overrun_clr) ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_rx_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
      out_q    <= '0;
      rd_req_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovr_q    <= ovr_d;
      out_q    <= out_d;
      rd_req_q <= rd_req_d;
    end
  end

  rx_iq_buf_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk_in (clk_in),
    .we     (ram_we),
    .waddr  (wr_ptr_q),
    .wdata  (wr_entry),
    .raddr  (rd_ptr_q),
    .rdata  (ram_rdata)
  );

`ifdef RX_IQ_BUFFER_HWM_EN
  logic [ADDR_W:0] hwm_q, hwm_d;

  // Tracks registered level, so it trails level by one cycle.
  always_comb begin
    hwm_d = hwm_q;
    if (flush || overrun_clr)  hwm_d = '0;
    else if (level_q > hwm_q)  hwm_d = level_q;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_rx_n) hwm_q <= '0;
    else             hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

  assign RX1_I      = out_q[4*IQ_W-1 -: IQ_W];
  assign RX1_Q      = out_q[3*IQ_W-1 -: IQ_W];
  assign RX2_I      = out_q[2*IQ_W-1 -: IQ_W];
  assign RX2_Q      = out_q[IQ_W-1   -: IQ_W];
  assign in_empty   = empty_q;
  assign full       = full_q;
  assign level      = level_q;
  assign iq_overrun = ovr_q;
endmodule

// File: tb/tb_rx_iq_buffer.sv
// Directed self-checking bench for rx_iq_buffer (DEPTH=16, IQ_W=24).
module tb_rx_iq_buffer;
  import rx_iq_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_rx_n, flush, rx_valid, rd_req, overrun_clr;
  logic [23:0] rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in;
  logic [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic        in_empty, full, iq_overrun;
  logic [4:0]  level;
`ifdef RX_IQ_BUFFER_HWM_EN
  logic [4:0]  hwm;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  rx_iq_buffer #(.DEPTH(16), .IQ_W(24)) dut (
    .clk_in      (clk_in),
    .reset_rx_n  (reset_rx_n),
    .flush       (flush),
    .rx_valid    (rx_valid),
    .rx1_i_in    (rx1_i_in),
    .rx1_q_in    (rx1_q_in),
    .rx2_i_in    (rx2_i_in),
    .rx2_q_in    (rx2_q_in),
    .rd_req      (rd_req),
    .overrun_clr (overrun_clr),
    .RX1_I       (RX1_I),
    .RX1_Q       (RX1_Q),
    .RX2_I       (RX2_I),
    .RX2_Q       (RX2_Q),
    .in_empty    (in_empty),
    .full        (full),
    .level       (level),
    .iq_overrun  (iq_overrun)
`ifdef RX_IQ_BUFFER_HWM_EN
    ,
    .hwm         (hwm)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_sample(input logic [23:0] v);
    iq_quad_t e;
    e.rx1_i = v;
    e.rx1_q = v + 24'h100;
    e.rx2_i = v + 24'h200;
    e.rx2_q = v + 24'h300;
    {rx1_i_in, rx1_q_in, rx2_i_in, rx2_q_in} = e;
  endtask

  task automatic push(input logic [23:0] v);
    set_sample(v);
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Rising edge of rd_req; returns with outputs one cycle after the edge, then drops rd_req.
  task automatic pop_edge(output logic [23:0] v);
    rd_req = 1'b1;
    tick();
    v = RX1_I;
    rd_req = 1'b0;
    tick();
  endtask

  logic [23:0] v;

  initial begin
    reset_rx_n = 1'b0; flush = 1'b0; rx_valid = 1'b0; rd_req = 1'b0; overrun_clr = 1'b0;
    set_sample(24'h0);
    tick(); tick();
    reset_rx_n = 1'b1;
    tick();

    chk("rst_empty", in_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovr", iq_overrun, 0);
    chk("rst_rx", {RX1_I, RX1_Q, RX2_I, RX2_Q}, 0);

    // Basic ordering
    push(24'h1); push(24'h2); push(24'h3);
    chk("w3_level", level, 3);
    chk("w3_empty", in_empty, 0);
    rd_req = 1'b1; tick();
    chk("p1_rx1i", RX1_I, 24'h1);
    chk("p1_rx2q", RX2_Q, 24'h301);
    chk("p1_level", level, 2);
    rd_req = 1'b0; tick();
    pop_edge(v); chk("p2_rx1i", v, 24'h2);
    pop_edge(v); chk("p3_rx1i", v, 24'h3);
    chk("p3_rx1q", RX1_Q, 24'h103);
    chk("p3_rx2i", RX2_I, 24'h203);
    chk("p3_level", level, 0);
    chk("p3_empty", in_empty, 1);

    // Held rd_req pops once
    push(24'h10); push(24'h11); push(24'h12); push(24'h13);
    chk("hold_pre_level", level, 4);
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rd_req = 1'b0; tick();
    chk("hold_level", level, 3);
    chk("hold_rx1i", RX1_I, 24'h10);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl0_level", level, 0);
    chk("fl0_rx1i", RX1_I, 24'h10);

    // Fill, overflow, overrun clear
    for (int k = 1; k <= 16; k++) push(24'(k));
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    chk("fill_ovr0", iq_overrun, 0);
    push(24'h11);
    chk("drop_ovr", iq_overrun, 1);
    chk("drop_level", level, 16);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("clr_ovr", iq_overrun, 0);
    // Drop and clear in the same cycle: set wins
    set_sample(24'h77); rx_valid = 1'b1; overrun_clr = 1'b1; tick();
    rx_valid = 1'b0; overrun_clr = 1'b0;
    chk("setwins_ovr", iq_overrun, 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("clr2_ovr", iq_overrun, 0);

    // Full + write + pop in the same cycle
    set_sample(24'h99); rx_valid = 1'b1; rd_req = 1'b1; tick();
    rx_valid = 1'b0;
    chk("fwp_rx1i", RX1_I, 24'h1);
    chk("fwp_level", level, 16);
    chk("fwp_full", full, 1);
    chk("fwp_ovr", iq_overrun, 0);
    rd_req = 1'b0; tick();
    for (int k = 2; k <= 16; k++) begin
      pop_edge(v);
      chk($sformatf("drain%0d", k), v, 24'(k));
    end
    pop_edge(v); chk("drain_last", v, 24'h99);
    chk("drain_empty", in_empty, 1);
    chk("drain_level", level, 0);

    // Pop on empty is ignored
    pop_edge(v);
    chk("epop_rx1i", v, 24'h99);
    chk("epop_rx2q", RX2_Q, 24'h399);
    chk("epop_empty", in_empty, 1);
    chk("epop_ovr", iq_overrun, 0);

    // Empty + write + pop: write only, no fall-through
    set_sample(24'h42); rx_valid = 1'b1; rd_req = 1'b1; tick();
    rx_valid = 1'b0; rd_req = 1'b0;
    chk("ewp_level", level, 1);
    chk("ewp_rx1i", RX1_I, 24'h99);
    tick();
    pop_edge(v); chk("ewp_pop", v, 24'h42);

    // Flush with level 5
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 0; k < 5; k++) push(24'h50 + 24'(k));
    tick();
    chk("fl_pre_level", level, 5);
`ifdef RX_IQ_BUFFER_HWM_EN
    chk("hwm_pre", hwm, 5);
`endif
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_empty", in_empty, 1);
    chk("fl_full", full, 0);
    chk("fl_rx1i", RX1_I, 24'h42);
`ifdef RX_IQ_BUFFER_HWM_EN
    chk("hwm_post", hwm, 0);
`endif
    pop_edge(v);
    chk("fl_pop_rx1i", v, 24'h42);
    chk("fl_pop_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
